snd_cmd_rtx: RTL and testbench
==============================

SND_CMD_RTX -- requirements
Module: snd_cmd_rtx

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: command ROM address width.
REQ-002 SHALL have parameter LEN_W, default 4: command length field width.
REQ-003 SHALL have parameter TERM_BYTE, default 8'h0A: response terminator byte.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1_000_000: response wait limit in clk cycles (>=2).
REQ-005 SHALL have parameter MAX_RETRY, default 2: retransmissions allowed after the first attempt (0..7).
REQ-006 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port send  input  1  start request, sampled only in IDLE.
REQ-009 SHALL have port cmd_start  input  ADDR_W  first ROM address, latched with send.
REQ-010 SHALL have port cmd_len  input  LEN_W  byte count, latched with send.
REQ-011 SHALL have port rom_addr  output  ADDR_W  registered ROM address.
REQ-012 SHALL have port rom_data  input  8  ROM data, valid one cycle after rom_addr.
REQ-013 SHALL have port trmt  output  1  one-cycle UART transmit strobe.
REQ-014 SHALL have port tx_data  output  8  byte to UART, equals rom_data.
REQ-015 SHALL have port tx_done  input  1  UART byte-complete flag.
REQ-016 SHALL have port rx_rdy  input  1  UART receive-valid flag.
REQ-017 SHALL have port rx_data  input  8  UART received byte.
REQ-018 SHALL have port clr_rx_rdy  output  1  UART receive-flag clear.
REQ-019 SHALL have port busy  output  1  high in every state except IDLE.
REQ-020 SHALL have port done  output  1  one-cycle pulse on return to IDLE.
REQ-021 SHALL have port resp_rcvd  output  1  one-cycle pulse on terminator accepted.
REQ-022 SHALL have port timeout_err  output  1  sticky failure flag.
REQ-023 SHALL have port retry_cnt  output  3  retransmissions used in current/last command.

Function
REQ-024 SHALL implement states IDLE, LOAD, SEND, WAIT_TX, WAIT_RESP, FIN.
REQ-025 IDLE: send=1 with cmd_len!=0 SHALL latch cmd_start/cmd_len, set rom_addr=cmd_start, clear timeout_err and retry_cnt, and go to LOAD; cmd_len=0 SHALL be ignored.
REQ-026 LOAD SHALL last exactly one cycle, then go to SEND.
REQ-027 SEND SHALL assert trmt for exactly one cycle, then go to WAIT_TX; the first trmt SHALL occur 2 cycles after the send-sample edge.
REQ-028 WAIT_TX on tx_done: if bytes sent < latched length, SHALL increment rom_addr (modulo 2^ADDR_W) and go to LOAD; otherwise SHALL clear the timer and go to WAIT_RESP.
REQ-029 Exactly cmd_len bytes SHALL be transmitted per attempt, from addresses cmd_start .. cmd_start+cmd_len-1 (wrapping).
REQ-030 WAIT_RESP: rx_rdy=1 with rx_data==TERM_BYTE SHALL pulse resp_rcvd and go to FIN; other bytes SHALL be discarded.
REQ-031 WAIT_RESP timer SHALL count every cycle; on reaching TIMEOUT_CYC-1 without terminator: if retry_cnt<MAX_RETRY, increment retry_cnt, reload rom_addr=latched start, go to LOAD; else set timeout_err and go to FIN.
REQ-032 Terminator and timeout expiry in the same cycle: terminator SHALL win.
REQ-033 FIN SHALL pulse done for one cycle and go to IDLE.
REQ-034 clr_rx_rdy SHALL equal rx_rdy in every state (all received bytes consumed).
REQ-035 send while busy=1 SHALL be ignored with no effect.
REQ-036 tx_done outside WAIT_TX SHALL be ignored.
REQ-037 timeout_err and retry_cnt SHALL hold until the next accepted send.

Reset
REQ-038 rst_n low SHALL immediately force IDLE, rom_addr=0, trmt=0, busy=0, done=0, resp_rcvd=0, timeout_err=0, retry_cnt=0, timer=0, byte counter=0.
REQ-039 Reset mid-command SHALL abort with no further trmt; no done pulse SHALL be produced.

Verification
REQ-040 send, cmd_start=5'd3, cmd_len=4 -> trmt 4 times with rom_addr 3,4,5,6; reply 8'h0A -> resp_rcvd, done, retry_cnt=0, timeout_err=0.
REQ-041 cmd_start=5'd30, cmd_len=3 -> addresses 30,31,0 transmitted.
REQ-042 TIMEOUT_CYC=100, MAX_RETRY=2, no reply -> 3 full transmissions, then timeout_err=1, retry_cnt=2, done pulse, no resp_rcvd.
REQ-043 Reply 8'h55 then 8'h0A -> 8'h55 discarded with clr_rx_rdy; resp_rcvd only on 8'h0A.
REQ-044 send pulsed during WAIT_TX; and send with cmd_len=0 in IDLE -> no effect, busy unchanged.
REQ-045 rst_n low during second byte's WAIT_TX -> IDLE, busy=0, no trmt afterwards, no done pulse.

Source files
------------

// File: rtl/snd_cmd_rtx.sv
// Command sender: streams a ROM-resident command to a UART transmitter, then
// waits for a terminator byte, retransmitting on timeout up to MAX_RETRY times.
module snd_cmd_rtx #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned LEN_W       = 4,
    parameter logic [7:0]  TERM_BYTE   = 8'h0A,
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              send,
    input  logic [ADDR_W-1:0] cmd_start,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              trmt,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              clr_rx_rdy,
    output logic              busy,
    output logic              done,
    output logic              resp_rcvd,
    output logic              timeout_err,
    output logic [2:0]        retry_cnt
);

    localparam int unsigned TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_TX, WAIT_RESP, FIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] start_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  byte_cnt;
    logic [TMR_W-1:0]  timer;

    logic accept, next_byte, last_byte, do_retry, give_up;
    logic term_hit, expire;

    assign tx_data    = rom_data;
    assign clr_rx_rdy = rx_rdy;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        trmt      = 1'b0;
        done      = 1'b0;
        resp_rcvd = 1'b0;
        accept    = 1'b0;
        next_byte = 1'b0;
        last_byte = 1'b0;
        do_retry  = 1'b0;
        give_up   = 1'b0;
        term_hit  = rx_rdy && (rx_data == TERM_BYTE);
        expire    = (timer == TMR_W'(TIMEOUT_CYC - 1));
        case (state)
            IDLE: begin
                if (send && (cmd_len != '0)) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = SEND;
            SEND: begin
                trmt      = 1'b1;
                state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    if (byte_cnt < len_q) begin
                        next_byte = 1'b1;
                        state_nxt = LOAD;
                    end else begin
                        last_byte = 1'b1;
                        state_nxt = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                // Terminator takes priority over a coincident timer expiry.
                if (term_hit) begin
                    resp_rcvd = 1'b1;
                    state_nxt = FIN;
                end else if (expire) begin
                    if (retry_cnt < 3'(MAX_RETRY)) begin
                        do_retry  = 1'b1;
                        state_nxt = LOAD;
                    end else begin
                        give_up   = 1'b1;
                        state_nxt = FIN;
                    end
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rom_addr    <= '0;
            start_q     <= '0;
            len_q       <= '0;
            byte_cnt    <= '0;
            timer       <= '0;
            retry_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                start_q     <= cmd_start;
                len_q       <= cmd_len;
                rom_addr    <= cmd_start;
                byte_cnt    <= '0;
                retry_cnt   <= '0;
                timeout_err <= 1'b0;
            end
            if (trmt)
                byte_cnt <= byte_cnt + 1'b1;
            if (next_byte)
                rom_addr <= rom_addr + 1'b1;
            if (last_byte)
                timer <= '0;
            else if (state == WAIT_RESP && !term_hit && !expire)
                timer <= timer + 1'b1;
            if (do_retry) begin
                retry_cnt <= retry_cnt + 3'd1;
                rom_addr  <= start_q;
                byte_cnt  <= '0;
            end
            if (give_up)
                timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_snd_cmd_rtx.sv
// Scoreboard bench for snd_cmd_rtx: directed commands with a synchronous ROM
// model and a simple UART model; a negedge monitor checks every trmt and done.
module tb_snd_cmd_rtx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       send;
    logic [4:0] cmd_start;
    logic [3:0] cmd_len;
    logic [4:0] rom_addr;
    logic [7:0] rom_data;
    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       clr_rx_rdy;
    logic       busy;
    logic       done;
    logic       resp_rcvd;
    logic       timeout_err;
    logic [2:0] retry_cnt;

    snd_cmd_rtx #(
        .ADDR_W(5),
        .LEN_W(4),
        .TERM_BYTE(8'h0A),
        .TIMEOUT_CYC(100),
        .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .send(send), .cmd_start(cmd_start),
        .cmd_len(cmd_len), .rom_addr(rom_addr), .rom_data(rom_data),
        .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done), .rx_rdy(rx_rdy),
        .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy), .busy(busy), .done(done),
        .resp_rcvd(resp_rcvd), .timeout_err(timeout_err), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_done;
        logic [4:0] addr;
        logic [7:0] data;
        logic [2:0] retry;
        logic       terr;
        logic       resp;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   trmt_seen   = 0;
    int   done_seen   = 0;
    bit   resp_flag   = 0;

    function automatic logic [7:0] rom_val(input logic [4:0] a);
        return {3'b110, a} ^ 8'h5A;
    endfunction

    always @(posedge clk) rom_data <= rom_val(rom_addr);

    // UART model: byte completes 4 edges after the strobe leaves SEND.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (trmt) begin
                repeat (3) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (resp_rcvd) resp_flag = 1;
                if (trmt) begin
                    trmt_seen++;
                    if (exp_q.size() == 0 || exp_q[0].is_done) begin
                        check("unexpected_trmt", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_addr", 32'(rom_addr), 32'(e.addr));
                        check("tx_data", 32'(tx_data), 32'(e.data));
                    end
                end
                if (done) begin
                    done_seen++;
                    if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_retry_cnt", 32'(retry_cnt), 32'(e.retry));
                        check("done_timeout_err", 32'(timeout_err), 32'(e.terr));
                        check("done_resp_rcvd", 32'(resp_flag), 32'(e.resp));
                    end
                    resp_flag = 0;
                end
            end
        end
    end

    task automatic push_tx(input logic [4:0] start, input int unsigned len);
        exp_t e;
        for (int unsigned i = 0; i < len; i++) begin
            e = '{is_done: 0, addr: 5'(start + 5'(i)), data: rom_val(5'(start + 5'(i))),
                  retry: '0, terr: 0, resp: 0};
            exp_q.push_back(e);
        end
    endtask

    task automatic push_done(input logic [2:0] r, input logic t, input logic rs);
        exp_t e;
        e = '{is_done: 1, addr: '0, data: '0, retry: r, terr: t, resp: rs};
        exp_q.push_back(e);
    endtask

    task automatic start_cmd(input logic [4:0] s, input logic [3:0] l);
        @(posedge clk);
        #1 send = 1'b1; cmd_start = s; cmd_len = l;
        @(posedge clk);
        #1 send = 1'b0;
        check("busy_after_send", 32'(busy), 32'd1);
        @(posedge clk);
        #1 check("first_trmt_latency", 32'(trmt), 32'd1);
    endtask

    task automatic wait_trmts(input int target);
        for (int i = 0; i < 3000 && trmt_seen < target; i++) @(posedge clk);
        #1;
        if (trmt_seen < target) check("trmt_wait_expired", 32'(trmt_seen), 32'(target));
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 3000 && done_seen < target; i++) @(posedge clk);
        #1;
        if (done_seen < target) check("done_wait_expired", 32'(done_seen), 32'(target));
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic exp_resp);
        @(posedge clk);
        #1 rx_rdy = 1'b1; rx_data = b;
        #1;
        check("clr_rx_rdy", 32'(clr_rx_rdy), 32'd1);
        check("resp_rcvd_on_byte", 32'(resp_rcvd), 32'(exp_resp));
        @(posedge clk);
        #1 rx_rdy = 1'b0;
        check("clr_rx_rdy_low", 32'(clr_rx_rdy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; send = 1'b0; cmd_start = '0; cmd_len = '0;
        rx_rdy = 1'b0; rx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_trmt", 32'(trmt), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_retry_cnt", 32'(retry_cnt), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;

        // zero-length command is ignored
        @(posedge clk);
        #1 send = 1'b1; cmd_start = 5'd9; cmd_len = 4'd0;
        @(posedge clk);
        #1 send = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_rom_addr", 32'(rom_addr), 32'd0);

        // start 3, len 4, terminator reply; send pulse while in WAIT_TX
        push_tx(5'd3, 4);
        push_done(3'd0, 1'b0, 1'b1);
        start_cmd(5'd3, 4'd4);
        @(posedge clk);
        #1 send = 1'b1; cmd_start = 5'd20; cmd_len = 4'd2;
        @(posedge clk);
        #1 send = 1'b0;
        check("busy_send_ignored", 32'(busy), 32'd1);
        wait_trmts(4);
        repeat (8) @(posedge clk);
        rx_byte(8'h0A, 1'b1);
        wait_done(1);
        check("cmd1_busy_end", 32'(busy), 32'd0);

        // wrap 30,31,0 with a discarded byte before the terminator
        push_tx(5'd30, 3);
        push_done(3'd0, 1'b0, 1'b1);
        start_cmd(5'd30, 4'd3);
        wait_trmts(7);
        repeat (8) @(posedge clk);
        rx_byte(8'h55, 1'b0);
        repeat (2) @(posedge clk);
        check("busy_after_0x55", 32'(busy), 32'd1);
        rx_byte(8'h0A, 1'b1);
        wait_done(2);

        // no reply: three full attempts then failure
        push_tx(5'd10, 3);
        push_tx(5'd10, 3);
        push_tx(5'd10, 3);
        push_done(3'd2, 1'b1, 1'b0);
        start_cmd(5'd10, 4'd3);
        wait_done(3);
        repeat (4) @(posedge clk);
        #1;
        check("terr_sticky", 32'(timeout_err), 32'd1);
        check("retry_sticky", 32'(retry_cnt), 32'd2);
        check("busy_after_fail", 32'(busy), 32'd0);

        // reset during second byte's WAIT_TX
        push_tx(5'd7, 2);
        start_cmd(5'd7, 4'd4);
        wait_trmts(18);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_trmt", 32'(trmt), 32'd0);
        check("abort_rom_addr", 32'(rom_addr), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_no_done", 32'(done_seen), 32'd3);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
